// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module      : run_controller
// Description : Run sequencer for the 9-bit single-cycle processor.
//               Clears the register file, waits for start to drop, runs until
//               halt or a cycle limit, then reports done.
// Revision    : 1.0 - initial release
// ============================================================================
module run_controller #(
    parameter int unsigned         NUM_REGS   = 4,
    parameter int unsigned         REG_ADDR_W = 2,
    parameter int unsigned         CYCLE_W    = 16,
    parameter logic [CYCLE_W-1:0]  MAX_CYCLES = 16'd65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    output logic                  pc_reset,
    output logic                  pc_en,
    output logic                  clr_en,
    output logic [REG_ADDR_W-1:0] clr_addr,
    output logic                  run,
    output logic                  done,
    output logic                  timeout,
    output logic [CYCLE_W-1:0]    cycle_count
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_clear = 3'd1;
    localparam logic [2:0] c_st_hold  = 3'd2;
    localparam logic [2:0] c_st_run   = 3'd3;
    localparam logic [2:0] c_st_fin   = 3'd4;

    localparam logic [REG_ADDR_W-1:0] c_last_addr  = REG_ADDR_W'(NUM_REGS - 1);
    localparam logic [CYCLE_W-1:0]    c_last_cycle = MAX_CYCLES - CYCLE_W'(1);

    logic [2:0]            r_state;
    logic [REG_ADDR_W-1:0] r_clr_cnt;
    logic                  r_done;
    logic                  r_timeout;
    logic [CYCLE_W-1:0]    r_cycle_count;

    logic w_in_clear;
    logic w_in_run;

    assign w_in_clear = (r_state == c_st_clear);
    assign w_in_run   = (r_state == c_st_run);

    assign pc_reset    = w_in_clear;
    assign clr_en      = w_in_clear;
    assign clr_addr    = w_in_clear ? r_clr_cnt : '0;
    assign run         = w_in_run;
    // The halting instruction must not advance the PC.
    assign pc_en       = w_in_run & ~halt;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_clr_cnt     <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state       <= c_st_clear;
                        r_clr_cnt     <= '0;
                        r_timeout     <= 1'b0;
                        r_cycle_count <= '0;
                    end
                end
                c_st_clear: begin
                    // start is deliberately ignored: the sweep always completes.
                    if (r_clr_cnt == c_last_addr) begin
                        r_clr_cnt <= '0;
                        r_state   <= c_st_hold;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + REG_ADDR_W'(1);
                    end
                end
                c_st_hold: begin
                    if (!start) begin
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_cycle_count <= r_cycle_count + CYCLE_W'(1);
                    if (halt) begin
                        r_state   <= c_st_fin;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b0;
                    end else if (r_cycle_count == c_last_cycle) begin
                        r_state   <= c_st_fin;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                c_st_fin: begin
                    if (start) begin
                        r_state       <= c_st_clear;
                        r_clr_cnt     <= '0;
                        r_done        <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_cycle_count <= '0;
                    end
                end
                default: begin
                    r_state       <= c_st_idle;
                    r_clr_cnt     <= '0;
                    r_done        <= 1'b0;
                    r_timeout     <= 1'b0;
                    r_cycle_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/run_controller.md
Name: run_controller

Overview:
- Top-level run sequencer for the 9-bit single-cycle processor. It implements the start/hold/program/done protocol.
- On a start request it clears the PC and sweeps the register file to zero. It then holds while start stays high, and enables PC advance once start drops.
- It stops on the decoder's halt indication or on a cycle-limit timeout, then raises done.
- It sits beside program_counter and register_file and gates their enables; the testbench drives only start and watches done.

Parameters:
- NUM_REGS, 4, number of register-file entries swept during clear.
- REG_ADDR_W, 2, width of the clear address; 2**REG_ADDR_W >= NUM_REGS.
- CYCLE_W, 16, width of the run-cycle counter.
- MAX_CYCLES, 16'd65535, run-cycle limit before forced stop; must satisfy 1 <= MAX_CYCLES <= 2**CYCLE_W-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; single clock domain.
- start  input  1  testbench start level.
- halt  input  1  halt decode from control_decoder; sampled only in RUN.
- pc_reset  output  1  forces PC to 0.
- pc_en  output  1  PC advance enable.
- clr_en  output  1  register-file clear write strobe (writes 0).
- clr_addr  output  REG_ADDR_W  register index being cleared.
- run  output  1  high while executing program.
- done  output  1  program finished (registered).
- timeout  output  1  finish caused by cycle limit (registered).
- cycle_count  output  CYCLE_W  RUN cycles executed this program (registered).

Behaviour:
- States: IDLE, CLEAR, HOLD, RUN, FIN.
- Reset: the next edge forces IDLE and clears the clear counter. done=0, timeout=0, cycle_count=0.
  - This applies from any state, including mid-CLEAR or mid-RUN.
  - All outputs read 0 from the cycle after reset is sampled.
- Moore outputs are decoded from the state register:
  - pc_reset = clr_en = (CLEAR).
  - clr_addr = clear counter in CLEAR, else 0.
  - run = (RUN).
- Mealy output: pc_en = RUN & ~halt. The halting instruction does not advance the PC.
- IDLE: start=1 -> CLEAR, else stay.
- CLEAR: one register per cycle, clr_addr = 0,1,...,NUM_REGS-1, so exactly NUM_REGS cycles.
  - After the last address -> HOLD; the counter returns to 0.
  - start is not sampled in CLEAR; the sweep always completes.
- HOLD: start=1 stay; start=0 -> RUN.
- RUN: each cycle cycle_count <= cycle_count+1.
  - halt=1 -> FIN, timeout<=0, done<=1.
  - Else if cycle_count == MAX_CYCLES-1 -> FIN, timeout<=1, done<=1; cycle_count ends at MAX_CYCLES.
  - Halt and limit in the same cycle: halt wins, timeout=0.
  - The halting cycle is counted.
  - start is ignored in RUN.
- FIN: done=1, pc_en=0, registers frozen; cycle_count and timeout hold.
  - start=1 -> CLEAR; on that edge done<=0, timeout<=0, cycle_count<=0.
- Entry from IDLE into CLEAR also zeroes cycle_count and timeout.
- done rises the cycle after the terminating RUN cycle. Minimum latency start-fall -> RUN is 1 cycle.
- Illegal state encodings recover to IDLE on the next edge.
- No arithmetic wraps: cycle_count never exceeds MAX_CYCLES.

Test Plan:
- Reset: reset=1 for 2 cycles with start=1 -> all outputs 0. First cycle after release, start=1 -> next cycle clr_en=1, clr_addr=0.
- Nominal, NUM_REGS=4: start=1 for 6 cycles then 0, halt pulsed on the 6th RUN cycle ->
  - clr_en/pc_reset high 4 cycles with clr_addr 0,1,2,3, then HOLD until start falls.
  - pc_en high 5 cycles, low on the 6th.
  - done=1 the following cycle, cycle_count=6, timeout=0.
- Timeout, MAX_CYCLES=8, halt held 0 -> run high exactly 8 cycles, then done=1, timeout=1, cycle_count=8; pc_en never drops early.
- Simultaneous, MAX_CYCLES=8: halt=1 on the 8th RUN cycle -> done=1, timeout=0, cycle_count=8, pc_en=0 that cycle.
- Restart: in FIN with cycle_count=6, assert start -> next cycle done=0, cycle_count=0, clr_addr=0, and the sweep repeats. start pulsed during the prior RUN had no effect.
- Reset mid-operation: reset during the 3rd RUN cycle, and separately during clr_addr=2 -> next cycle IDLE, all outputs 0. A following start restarts the sweep at clr_addr=0.
